// File: rtl/collenda_reset_poller.sv
// Avalon-MM master that polls a one-bit button PIO, debounces it and turns each press
// into a reset_req pulse and a press count. Define RESET_POLLER_IRQ_EN to add irq/irq_ack.
module collenda_reset_poller #(
  parameter int POLL_PERIOD      = 50000,
  parameter int READ_LATENCY     = 1,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int PULSE_CYCLES     = 16,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        button_state,
  output logic        reset_req,
  output logic [7:0]  press_count
`ifdef RESET_POLLER_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_ack
`endif
);

  localparam int CNT_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [3:0]       agree_q, agree_d;
  logic [7:0]       pulse_q, pulse_d;
  logic [7:0]       count_q, count_d;
  logic             btn_q, btn_d;
  logic             rd_q, rd_d;
  logic             poll_req;
  logic             capture;
  logic             pressed;
  logic             press_edge;
  logic             unused_readdata;

  assign unused_readdata = ^avm_readdata[31:1];

  always_comb begin
    // The interval counter never stalls, so reads stay exactly POLL_PERIOD apart.
    poll_req = (ivl_q == CNT_W'(POLL_PERIOD - 1));
    ivl_d    = poll_req ? '0 : ivl_q + CNT_W'(1);

    state_d = state_q;
    lat_d   = lat_q;
    rd_d    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (poll_req) begin
          state_d = ST_READ;
          rd_d    = 1'b1;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
        lat_d   = LAT_W'(1);
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY)) begin
          capture = 1'b1;
          state_d = ST_IDLE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        lat_d   = '0;
      end
    endcase

    pressed    = (ACTIVE_LOW != 0) ? ~avm_readdata[0] : avm_readdata[0];
    agree_d    = agree_q;
    btn_d      = btn_q;
    press_edge = 1'b0;
    if (capture) begin
      if (pressed != btn_q) begin
        if (agree_q == 4'(DEBOUNCE_SAMPLES - 1)) begin
          btn_d      = ~btn_q;
          agree_d    = '0;
          press_edge = ~btn_q;
        end else begin
          agree_d = agree_q + 4'd1;
        end
      end else begin
        agree_d = '0;
      end
    end

    count_d = press_edge ? count_q + 8'd1 : count_q;
    // A press reloads the full width, so a retrigger extends the pulse without a gap.
    if (press_edge) begin
      pulse_d = 8'(PULSE_CYCLES);
    end else if (pulse_q != 8'd0) begin
      pulse_d = pulse_q - 8'd1;
    end else begin
      pulse_d = pulse_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ivl_q   <= '0;
      lat_q   <= '0;
      agree_q <= '0;
      pulse_q <= '0;
      count_q <= '0;
      btn_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      lat_q   <= lat_d;
      agree_q <= agree_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      btn_q   <= btn_d;
      rd_q    <= rd_d;
    end
  end

  assign avm_address  = 2'b00;
  assign avm_read     = rd_q;
  assign button_state = btn_q;
  assign reset_req    = (pulse_q != 8'd0);
  assign press_count  = count_q;

`ifdef RESET_POLLER_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (press_edge) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_collenda_reset_poller.sv
// Scoreboarded bench for collenda_reset_poller: a driver feeds the button PIO model per poll,
// a monitor checks timing, debounce results and the reset_req window against a reference model.
module tb_collenda_reset_poller;

  localparam int P   = 8;
  localparam int RL  = 1;
  localparam int DS  = 3;
  localparam int PC  = 4;
  localparam int P2  = 4;
  localparam int DS2 = 1;
  localparam int PC2 = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT and its responder
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic        button_state;
  logic        reset_req;
  logic [7:0]  press_count;
  logic        in_port = 1'b1;

  // retrigger DUT and its responder
  logic [1:0]  avm_address_2;
  logic        avm_read_2;
  logic [31:0] avm_readdata_2 = 32'd0;
  logic        button_state_2;
  logic        reset_req_2;
  logic [7:0]  press_count_2;
  logic        in_port_2 = 1'b1;

`ifdef RESET_POLLER_IRQ_EN
  logic irq, irq_2;
  logic irq_ack = 1'b0;
  logic irq_ack_2 = 1'b0;
`endif

  always @(posedge clk) if (avm_read)   avm_readdata   <= {31'd0, in_port};
  always @(posedge clk) if (avm_read_2) avm_readdata_2 <= {31'd0, in_port_2};

  collenda_reset_poller #(
    .POLL_PERIOD(P), .READ_LATENCY(RL), .DEBOUNCE_SAMPLES(DS), .PULSE_CYCLES(PC), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .button_state(button_state), .reset_req(reset_req),
    .press_count(press_count)
`ifdef RESET_POLLER_IRQ_EN
    , .irq(irq), .irq_ack(irq_ack)
`endif
  );

  collenda_reset_poller #(
    .POLL_PERIOD(P2), .READ_LATENCY(RL), .DEBOUNCE_SAMPLES(DS2), .PULSE_CYCLES(PC2), .ACTIVE_LOW(1)
  ) dut_2 (
    .clk(clk), .reset_n(reset_n), .avm_address(avm_address_2), .avm_read(avm_read_2),
    .avm_readdata(avm_readdata_2), .button_state(button_state_2), .reset_req(reset_req_2),
    .press_count(press_count_2)
`ifdef RESET_POLLER_IRQ_EN
    , .irq(irq_2), .irq_ack(irq_ack_2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: debounced state, run of disagreeing samples, press count
  logic       m_btn = 1'b0;
  int         m_run = 0;
  logic [7:0] m_cnt = 8'd0;

  // scoreboard: {press, button_state, press_count} per captured sample
  logic [9:0] exp_q[$];
  int         due_q[$];
  logic       mon_en  = 1'b0;
  int         last_rd = -1;
  int         req_end = -1;

  task automatic model_reset();
    m_btn = 1'b0; m_run = 0; m_cnt = 8'd0;
    exp_q.delete(); due_q.delete();
    last_rd = -1; req_end = -1;
  endtask

  // driver: waits for the next read strobe and presents this poll's button level
  task automatic poll(input logic v, output int waited);
    int   n;
    logic press;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_read && n < 100);
    waited = n;
    if (!avm_read) begin
      check("poll_timeout", 0, 1);
    end else begin
      in_port = v;
      press = 1'b0;
      if (~v != m_btn) begin
        m_run++;
        if (m_run == DS) begin
          m_btn = ~v;
          m_run = 0;
          if (m_btn) begin
            m_cnt++;
            press = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      exp_q.push_back({press, m_btn, m_cnt});
    end
  endtask

  task automatic p(input logic v);
    int w;
    poll(v, w);
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [9:0] e;
      if (avm_read) begin
        if (last_rd >= 0) check("read_period", cyc - last_rd, P);
        last_rd = cyc;
        due_q.push_back(cyc + 2);
      end
      check("avm_address", int'(avm_address), 0);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("button_state", int'(button_state), int'(e[8]));
          check("press_count", int'(press_count), int'(e[7:0]));
          if (e[9]) req_end = cyc + PC - 1;
        end
      end
      check("reset_req", int'(reset_req), (cyc <= req_end) ? 1 : 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_avm_read"}, int'(avm_read), 0);
    check({tag, "_avm_address"}, int'(avm_address), 0);
    check({tag, "_button_state"}, int'(button_state), 0);
    check({tag, "_reset_req"}, int'(reset_req), 0);
    check({tag, "_press_count"}, int'(press_count), 0);
  endtask

  task automatic retrigger_test();
    int n, r, hi, first, last;
    n = 0; r = 0; hi = 0; first = -1; last = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_read_2 && n < 100);
    check("retrig_read_seen", int'(avm_read_2), 1);
    in_port_2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (avm_read_2) begin
        r++;
        in_port_2 = (r == 2) ? 1'b0 : 1'b1;
      end
      if (reset_req_2) begin
        hi++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("retrig_start", first, 1);
    check("retrig_high_cycles", hi, 2 * P2 + PC2);
    check("retrig_no_gap", last - first + 1, 2 * P2 + PC2);
    check("retrig_press_count", int'(press_count_2), 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!avm_read && w < 100);
    check("first_read_wait", w, P);

    // abandon this read: the pressed sample it returns must never reach the debouncer
    in_port = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    poll(1'b0, w);
    check("restart_read_wait", w, P);

    p(1'b0);
    repeat (4) p(1'b1);
    repeat (3) p(1'b0);
    repeat (3) p(1'b1);
    p(1'b0); p(1'b0); p(1'b1); p(1'b0); p(1'b0); p(1'b0);
    repeat (3) p(1'b1);

`ifdef RESET_POLLER_IRQ_EN
    check("irq_set", int'(irq), 1);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    check("irq_ack_clear", int'(irq), 0);
    repeat (3) p(1'b0);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    check("irq_set_wins", int'(irq), 1);
    repeat (3) p(1'b1);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
`endif

    while (m_cnt != 8'd0) begin
      repeat (3) p(1'b0);
      repeat (3) p(1'b1);
    end
    repeat (2) @(negedge clk);
    check("press_count_wrap", int'(press_count), 0);

    repeat (60) begin
      v = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 4)) p(v);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("exp_q_drained", exp_q.size(), 0);

    retrigger_test();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
